// File: rtl/fib_05_pkg.sv
// Shared definitions for the fib_05 output monitor: error-code bit positions,
// monitor state encoding and the default datapath width.
package fib_05_pkg;

  localparam int DEFAULT_W = 11;

  localparam int ERR_X = 0;
  localparam int ERR_Y = 1;
  localparam int ERR_I = 2;
  localparam int ERR_J = 3;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/fib_05_step_model.sv
// Combinational one-step model of the fib_05 datapath: given the previous
// sample and selector, produce the values the next sample must carry.
module fib_05_step_model
  import fib_05_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] px,
  input  logic [W-1:0] py,
  input  logic [W-1:0] pi,
  input  logic [W-1:0] pj,
  input  logic         psel,
  output logic [W-1:0] ex,
  output logic [W-1:0] ey,
  output logic [W-1:0] ei,
  output logic [W-1:0] ej
);

  // Sums truncate to W bits, so wrap-around is the intended behaviour.
  always_comb begin
    ex = px;
    ey = py;
    ei = pi;
    ej = pj + W'(1);
    if (psel) begin
      ex = px + py;
      ey = px;
      ei = pi + W'(1);
      ej = pj;
    end
  end

endmodule

// File: rtl/fib_05_monitor.sv
// Observer for the fib_05 datapath outputs: checks each sample against the
// step relation from the previous one and keeps sticky pass/fail diagnostics.
module fib_05_monitor
  import fib_05_pkg::*;
#(
  parameter int W            = DEFAULT_W,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  input  logic [W-1:0]     i,
  input  logic [W-1:0]     j,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             active,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [3:0]       first_err_code,
  output logic [CNT_W-1:0] first_err_cycle
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t         state;
  logic [W-1:0]   px, py, pi, pj;
  logic           psel;
  logic [W-1:0]   ex, ey, ei, ej;
  logic [3:0]     mis;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  fib_05_step_model #(.W(W)) u_step (
    .px  (px),
    .py  (py),
    .pi  (pi),
    .pj  (pj),
    .psel(psel),
    .ex  (ex),
    .ey  (ey),
    .ei  (ei),
    .ej  (ej)
  );

  always_comb begin
    mis        = '0;
    mis[ERR_X] = (x != ex);
    mis[ERR_Y] = (y != ey);
    mis[ERR_I] = (i != ei);
    mis[ERR_J] = (j != ej);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= PRIME;
      active          <= 1'b0;
      fail            <= 1'b0;
      err_cnt         <= '0;
      sample_cnt      <= '0;
      first_err_code  <= '0;
      first_err_cycle <= '0;
      px              <= '0;
      py              <= '0;
      pi              <= '0;
      pj              <= '0;
      psel            <= 1'b0;
    end else begin
      case (state)
        PRIME: begin
          px     <= x;
          py     <= y;
          pi     <= i;
          pj     <= j;
          psel   <= selector;
          state  <= CHECK;
          active <= 1'b1;
        end
        CHECK: begin
          px         <= x;
          py         <= y;
          pi         <= i;
          pj         <= j;
          psel       <= selector;
          sample_cnt <= sat_inc(sample_cnt);
          if (|mis) begin
            // Only the first failing sample is recorded; later ones just count.
            if (!fail) begin
              fail            <= 1'b1;
              first_err_code  <= mis;
              first_err_cycle <= sample_cnt;
            end
            err_cnt <= sat_inc(err_cnt);
            if (STOP_ON_FAIL) begin
              state  <= HALT;
              active <= 1'b0;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state  <= PRIME;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_05_monitor.sv
// Randomized self-checking bench for fib_05_monitor: a free-running and a
// stop-on-fail instance observe one stimulus stream and are scored against a model.
module tb_fib_05_monitor;

  localparam int W  = 11;
  localparam int M  = 1 << W;
  localparam int CA = 5;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          selector = 1'b0;
  logic [W-1:0]  x = '0, y = '0, i = '0, j = '0;

  logic          a_active, a_fail;
  logic [CA-1:0] a_err, a_smp, a_fcyc;
  logic [3:0]    a_code;
  logic          b_active, b_fail;
  logic [CB-1:0] b_err, b_smp, b_fcyc;
  logic [3:0]    b_code;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit primed;
    bit halted;
    int px, py, pi, pj;
    bit psel;
    bit fail;
    int err;
    int smp;
    int code;
    int fcyc;
  } mst_t;

  mst_t ma, mb;
  int tx, ty, ti, tj;

  always #5 clk = ~clk;

  fib_05_monitor #(.W(W), .CNT_W(CA), .STOP_ON_FAIL(1'b0)) u_mon (
    .clk(clk), .rst(rst), .selector(selector),
    .i(i), .j(j), .x(x), .y(y),
    .active(a_active), .fail(a_fail), .err_cnt(a_err), .sample_cnt(a_smp),
    .first_err_code(a_code), .first_err_cycle(a_fcyc)
  );

  fib_05_monitor #(.W(W), .CNT_W(CB), .STOP_ON_FAIL(1'b1)) u_halt (
    .clk(clk), .rst(rst), .selector(selector),
    .i(i), .j(j), .x(x), .y(y),
    .active(b_active), .fail(b_fail), .err_cnt(b_err), .sample_cnt(b_smp),
    .first_err_code(b_code), .first_err_cycle(b_fcyc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference monitor: one edge of the observer described as plain integer rules.
  function automatic mst_t mstep(input mst_t s, input bit r, input bit sel,
                                 input int vx, input int vy, input int vi, input int vj,
                                 input bit stop, input int cmax);
    mst_t n;
    int ex, ey, ei, ej, code;
    n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (s.halted) return n;
    if (s.primed) begin
      if (s.psel) begin
        ex = (s.px + s.py) % M; ey = s.px; ei = (s.pi + 1) % M; ej = s.pj;
      end else begin
        ex = s.px; ey = s.py; ei = s.pi; ej = (s.pj + 1) % M;
      end
      code = ((vx != ex) ? 1 : 0) + ((vy != ey) ? 2 : 0) +
             ((vi != ei) ? 4 : 0) + ((vj != ej) ? 8 : 0);
      if (code != 0) begin
        if (!s.fail) begin
          n.fail = 1'b1;
          n.code = code;
          n.fcyc = s.smp;
        end
        n.err = (s.err < cmax) ? s.err + 1 : s.err;
        if (stop) n.halted = 1'b1;
      end
      n.smp = (s.smp < cmax) ? s.smp + 1 : s.smp;
    end
    n.primed = 1'b1;
    n.px = vx; n.py = vy; n.pi = vi; n.pj = vj;
    n.psel = sel;
    return n;
  endfunction

  task automatic compare_all();
    check_eq("mon_active", 32'(a_active), 32'(ma.primed && !ma.halted));
    check_eq("mon_fail",   32'(a_fail),   32'(ma.fail));
    check_eq("mon_err",    32'(a_err),    ma.err);
    check_eq("mon_smp",    32'(a_smp),    ma.smp);
    check_eq("mon_code",   32'(a_code),   ma.code);
    check_eq("mon_fcyc",   32'(a_fcyc),   ma.fcyc);
    check_eq("halt_active", 32'(b_active), 32'(mb.primed && !mb.halted));
    check_eq("halt_fail",   32'(b_fail),   32'(mb.fail));
    check_eq("halt_err",    32'(b_err),    mb.err);
    check_eq("halt_smp",    32'(b_smp),    mb.smp);
    check_eq("halt_code",   32'(b_code),   mb.code);
    check_eq("halt_fcyc",   32'(b_fcyc),   mb.fcyc);
  endtask

  // One clock of a behavioural fib_05 top; cm corrupts the true state so a
  // faulty top keeps running from its wrong value.
  task automatic cyc(input bit r, input bit sel, input bit [3:0] cm);
    int nx, ny, ni, nj;
    if (cm[0]) tx = (tx + 1) % M;
    if (cm[1]) ty = (ty + 3) % M;
    if (cm[2]) ti = (ti + 1) % M;
    if (cm[3]) tj = (tj + 5) % M;
    rst = r;
    selector = sel;
    x = tx[W-1:0]; y = ty[W-1:0]; i = ti[W-1:0]; j = tj[W-1:0];
    @(posedge clk);
    ma = mstep(ma, r, sel, tx, ty, ti, tj, 1'b0, (1 << CA) - 1);
    mb = mstep(mb, r, sel, tx, ty, ti, tj, 1'b1, (1 << CB) - 1);
    if (sel) begin
      nx = (tx + ty) % M; ny = tx; ni = (ti + 1) % M; nj = tj;
    end else begin
      nx = tx; ny = ty; ni = ti; nj = (tj + 1) % M;
    end
    tx = nx; ty = ny; ti = ni; tj = nj;
    @(negedge clk);
    compare_all();
  endtask

  task automatic restart(input int sx, input int sy, input int si, input int sj);
    cyc(1'b1, 1'b0, 4'd0);
    tx = sx; ty = sy; ti = si; tj = sj;
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    tx = 1; ty = 1; ti = 0; tj = 0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    check_eq("rst_active", 32'(a_active), 32'd0);
    check_eq("rst_smp", 32'(a_smp), 32'd0);

    // Fibonacci steps from (1,1,0,0), then j-increment steps, then an x fault.
    tx = 1; ty = 1; ti = 0; tj = 0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'd0);
    check_eq("fib_smp", 32'(a_smp), 32'd2);
    check_eq("fib_fail", 32'(a_fail), 32'd0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 4'd0);
    check_eq("hold_err", 32'(a_err), 32'd0);
    cyc(1'b0, 1'b0, 4'b0001);
    check_eq("xerr_fail", 32'(a_fail), 32'd1);
    check_eq("xerr_code", 32'(a_code), 32'b0001);
    check_eq("xerr_cnt", 32'(a_err), 32'd1);

    // Combined y/i fault, then a later x fault that must not change the code.
    restart(3, 2, 1, 1);
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 4'b0110);
    check_eq("yi_code", 32'(a_code), 32'b0110);
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 4'b0001);
    check_eq("yi_code_kept", 32'(a_code), 32'b0110);
    check_eq("yi_cnt", 32'(a_err), 32'd2);

    // Wrap-around: 1500 + 900 = 352 mod 2048 must be accepted.
    restart(1500, 900, 5, 5);
    cyc(1'b0, 1'b1, 4'd0);
    check_eq("ovf_top_x", tx, 32'd352);
    cyc(1'b0, 1'b0, 4'd0);
    check_eq("ovf_fail", 32'(a_fail), 32'd0);
    check_eq("ovf_smp", 32'(a_smp), 32'd1);

    // Stop-on-fail instance: fault on sample 7, then frozen for 20 cycles.
    restart(2, 1, 0, 0);
    cyc(1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'($urandom_range(0, 1)), 4'd0);
    cyc(1'b0, 1'b0, 4'b0001);
    check_eq("stop_fcyc", 32'(b_fcyc), 32'd7);
    check_eq("stop_active", 32'(b_active), 32'd0);
    for (int k = 0; k < 20; k++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) == 0 ? $urandom_range(1, 15) : 0));
    check_eq("frz_smp", 32'(b_smp), 32'd8);
    check_eq("frz_err", 32'(b_err), 32'd1);
    check_eq("frz_active", 32'(b_active), 32'd0);

    // Reset after a failure clears everything; checking restarts cleanly.
    cyc(1'b1, 1'b0, 4'd0);
    check_eq("mrst_fail", 32'(a_fail), 32'd0);
    check_eq("mrst_err", 32'(b_err), 32'd0);
    cyc(1'b0, 1'b1, 4'd0);
    check_eq("mrst_prime_active", 32'(a_active), 32'd1);
    cyc(1'b0, 1'b1, 4'd0);
    check_eq("mrst_clean", 32'(a_fail), 32'd0);

    // Random traffic with sporadic faults and resets.
    for (int k = 0; k < 400; k++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      cyc(r, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 11) == 0 ? $urandom_range(1, 15) : 0));
    end

    // Sustained faults drive both counters of the narrow instance to saturation.
    restart(1, 0, 0, 0);
    cyc(1'b0, 1'b1, 4'd0);
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'($urandom_range(0, 1)), 4'b0001);
    check_eq("sat_err", 32'(a_err), 32'd31);
    check_eq("sat_smp", 32'(a_smp), 32'd31);
    check_eq("sat_fcyc", 32'(a_fcyc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
